// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan generator: state encoding, control bit
// positions and frame-buffer pixel field offsets.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  localparam int SCAN_EN_BIT = 0;
  localparam int BRIGHT_MSB  = 15;
  localparam int BRIGHT_LSB  = 8;

  localparam int UPPER_LSB = 0;
  localparam int LOWER_LSB = 16;
  localparam int R_OFF     = 8;
  localparam int G_OFF     = 4;
  localparam int B_OFF     = 0;

  function automatic logic [15:0] plane_len(input logic [15:0] base, input logic [2:0] plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// DISPLAY window down-counter with OE on-time compare.
// With HUB75_BRIGHTNESS_EN defined, on-time is scaled by (bright_i+1)/256; otherwise full window.
module hub75_oe_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  bright_i,
  output logic        done_o,
  output logic        oe_n_o
);

  logic [15:0] cnt_q;
  logic [15:0] thr_q;
  logic        active_q;
  logic        oe_n_q;
  logic [15:0] on_len;
  logic [15:0] cnt_dec;

`ifdef HUB75_BRIGHTNESS_EN
  logic [23:0] scaled;
  assign scaled = 24'(len_i) * (24'(bright_i) + 24'd1);
  assign on_len = scaled[23:8];
`else
  logic unused_bright;
  assign unused_bright = ^bright_i;
  assign on_len = len_i;
`endif

  assign cnt_dec = cnt_q - 16'd1;
  assign done_o  = active_q && (cnt_q == 16'd0);
  assign oe_n_o  = oe_n_q;

  // OE stays low while the remaining count is at or above len - on_len
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      thr_q    <= '0;
      active_q <= 1'b0;
      oe_n_q   <= 1'b1;
    end else if (clear_i) begin
      active_q <= 1'b0;
      oe_n_q   <= 1'b1;
    end else if (load_i) begin
      cnt_q    <= len_i - 16'd1;
      thr_q    <= len_i - on_len;
      active_q <= 1'b1;
      oe_n_q   <= (on_len == 16'd0);
    end else if (active_q) begin
      if (cnt_q == 16'd0) begin
        active_q <= 1'b0;
        oe_n_q   <= 1'b1;
      end else begin
        cnt_q  <= cnt_dec;
        oe_n_q <= !(cnt_dec >= thr_q);
      end
    end
  end

endmodule

// File: rtl/hub75_scan_gen.sv
// HUB75 row scanner with binary-code modulation, reading the frame buffer row by row.
// Optional HUB75_BRIGHTNESS_EN scales the OE on-time by control[15:8].
//   state   | meaning
//   IDLE    | waiting for scan enable and a non-zero row length
//   SHIFT   | read each column and clock the current plane's RGB bits into the panel
//   BLANK   | OE off, row address updated
//   LATCH   | latch shifted data into the panel drivers
//   DISPLAY | OE window of BASE_OE<<plane cycles, then next plane/row
module hub75_scan_gen
  import hub75_pkg::*;
#(
  parameter int SCAN_ROWS  = 32,
  parameter int COLOR_BITS = 4,
  parameter int BASE_OE    = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] control,
  input  logic [8:0]  pixels_per_row,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic        hub_clk,
  output logic        hub_lat,
  output logic        hub_oe_n,
  output logic [4:0]  hub_addr,
  output logic        frame_done,
  output logic        busy
);

  localparam int RW = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

  state_t        state_q;
  logic [RW-1:0] row_q;
  logic [PW-1:0] plane_q;
  logic [8:0]    ppr_q;
  logic [10:0]   cnt_q;
  logic          rd_en_q;
  logic [14:0]   rd_addr_q;
  logic          r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
  logic          hub_clk_q;
  logic          hub_lat_q;
  logic [4:0]    hub_addr_q;
  logic          frame_done_q;
  logic          busy_q;

  logic          scan_en;
  logic [10:0]   cnt_inc;
  logic [10:0]   shift_last;
  logic          plane_wrap;
  logic          row_wrap;
  logic          frame_wrap;
  logic [RW-1:0] row_d;
  logic [PW-1:0] plane_d;
  logic          tmr_load;
  logic          tmr_done;
  logic          tmr_oe_n;
  logic [15:0]   tmr_len;
  logic          unused_ok;

  assign scan_en    = control[SCAN_EN_BIT];
  assign cnt_inc    = cnt_q + 11'd1;
  assign shift_last = {1'b0, ppr_q, 1'b1};
  assign tmr_load   = (state_q == ST_LATCH) && scan_en;
  assign tmr_len    = plane_len(16'(BASE_OE), 3'(plane_q));
  assign unused_ok  = ^{control[31:16], control[7:1], rd_data[31:28], rd_data[15:12]};

  always_comb begin
    plane_wrap = (plane_q == PW'(COLOR_BITS - 1));
    row_wrap   = (row_q == RW'(SCAN_ROWS - 1));
    frame_wrap = plane_wrap && row_wrap;
    plane_d    = plane_wrap ? '0 : plane_q + 1'b1;
    row_d      = row_q;
    if (plane_wrap) row_d = row_wrap ? '0 : row_q + 1'b1;
  end

  hub75_oe_timer u_oe_timer (
    .clk_i   (pclk),
    .rst_i   (preset),
    .load_i  (tmr_load),
    .clear_i (!scan_en),
    .len_i   (tmr_len),
    .bright_i(control[BRIGHT_MSB:BRIGHT_LSB]),
    .done_o  (tmr_done),
    .oe_n_o  (tmr_oe_n)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      ppr_q        <= '0;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      r1_q         <= 1'b0;
      g1_q         <= 1'b0;
      b1_q         <= 1'b0;
      r2_q         <= 1'b0;
      g2_q         <= 1'b0;
      b2_q         <= 1'b0;
      hub_clk_q    <= 1'b0;
      hub_lat_q    <= 1'b0;
      hub_addr_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      hub_lat_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (scan_en && (pixels_per_row != 9'd0)) begin
            ppr_q     <= pixels_per_row;
            row_q     <= '0;
            plane_q   <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == shift_last) begin
            rd_en_q    <= 1'b0;
            hub_clk_q  <= 1'b0;
            hub_addr_q <= 5'(row_q);
            state_q    <= ST_BLANK;
          end else begin
            // even cycles read column cnt/2; odd cycles (from 3) clock the previous column
            cnt_q     <= cnt_inc;
            rd_en_q   <= !cnt_inc[0] && (cnt_inc[10:1] < {1'b0, ppr_q});
            rd_addr_q <= {6'(row_q), cnt_inc[9:1]};
            hub_clk_q <= cnt_inc[0] && (cnt_inc[10:1] != 10'd0);
            if (cnt_q[0] == RD_LATENCY[0]) begin
              r1_q <= rd_data[UPPER_LSB + R_OFF + int'(plane_q)];
              g1_q <= rd_data[UPPER_LSB + G_OFF + int'(plane_q)];
              b1_q <= rd_data[UPPER_LSB + B_OFF + int'(plane_q)];
              r2_q <= rd_data[LOWER_LSB + R_OFF + int'(plane_q)];
              g2_q <= rd_data[LOWER_LSB + G_OFF + int'(plane_q)];
              b2_q <= rd_data[LOWER_LSB + B_OFF + int'(plane_q)];
            end
          end
        end
        ST_BLANK: begin
          hub_lat_q <= 1'b1;
          state_q   <= ST_LATCH;
        end
        ST_LATCH: begin
          state_q <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (tmr_done) begin
            plane_q <= plane_d;
            row_q   <= row_d;
            if (frame_wrap) begin
              frame_done_q <= 1'b1;
              ppr_q        <= pixels_per_row;
            end
            if (frame_wrap && (pixels_per_row == 9'd0)) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q     <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= {6'(row_d), 9'd0};
              state_q   <= ST_SHIFT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // enable drop overrides everything except a frame_done pulse already scheduled
      if (!scan_en) begin
        state_q   <= ST_IDLE;
        row_q     <= '0;
        plane_q   <= '0;
        rd_en_q   <= 1'b0;
        hub_clk_q <= 1'b0;
        hub_lat_q <= 1'b0;
        busy_q    <= 1'b0;
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign r1         = r1_q;
  assign g1         = g1_q;
  assign b1         = b1_q;
  assign r2         = r2_q;
  assign g2         = g2_q;
  assign b2         = b2_q;
  assign hub_clk    = hub_clk_q;
  assign hub_lat    = hub_lat_q;
  assign hub_oe_n   = tmr_oe_n;
  assign hub_addr   = hub_addr_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hub75_scan_gen.sv
// Directed bench for hub75_scan_gen on a 2-row panel with a constant frame-buffer word.
module tb_hub75_scan_gen;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] control;
  logic [8:0]  pixels_per_row;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [31:0] rd_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic        hub_clk, hub_lat, hub_oe_n;
  logic [4:0]  hub_addr;
  logic        frame_done, busy;
  logic [31:0] ram_word;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_clk, n_lat, n_oe, n_fd, n_rd_adj;
  logic        prev_rd;
  logic [5:0]  rgb_clk;
  logic [4:0]  addr_lat;
  logic [14:0] addr_q[$];
  int          rd_cyc[$];

  logic [5:0] exp_rgb [4] = '{6'b111010, 6'b110100, 6'b100010, 6'b100100};
  int         exp_oe  [4] = '{8, 16, 32, 64};
`ifdef HUB75_BRIGHTNESS_EN
  int         exp_br  [4] = '{4, 8, 16, 32};
`else
  int         exp_br  [4] = '{8, 16, 32, 64};
`endif

  always #5 pclk = ~pclk;

  always @(posedge pclk) if (rd_en) rd_data <= ram_word;

  hub75_scan_gen #(
    .SCAN_ROWS (2),
    .COLOR_BITS(4),
    .BASE_OE   (8),
    .RD_LATENCY(1)
  ) dut (
    .pclk          (pclk),
    .preset        (preset),
    .control       (control),
    .pixels_per_row(pixels_per_row),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .r1            (r1),
    .g1            (g1),
    .b1            (b1),
    .r2            (r2),
    .g2            (g2),
    .b2            (b2),
    .hub_clk       (hub_clk),
    .hub_lat       (hub_lat),
    .hub_oe_n      (hub_oe_n),
    .hub_addr      (hub_addr),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    cyc++;
    if (hub_clk) begin
      n_clk++;
      rgb_clk = {r1, g1, b1, r2, g2, b2};
    end
    if (hub_lat) begin
      n_lat++;
      addr_lat = hub_addr;
    end
    if (!hub_oe_n) n_oe++;
    if (frame_done) n_fd++;
    if (rd_en) begin
      addr_q.push_back(rd_addr);
      rd_cyc.push_back(cyc);
      if (prev_rd) n_rd_adj++;
    end
    prev_rd = rd_en;
  endtask

  // One plane: from SHIFT start through the latch to the cycle after DISPLAY ends.
  task automatic run_plane();
    int guard;
    n_clk = 0; n_lat = 0; n_oe = 0; n_fd = 0;
    guard = 0;
    do begin tick(); guard++; end while (!hub_lat && guard < 3000);
    check("latch_reached", 32'(hub_lat), 32'd1);
    guard = 0;
    do begin tick(); guard++; end while (!rd_en && busy && guard < 300);
    check("plane_end_reached", 32'(rd_en || !busy), 32'd1);
  endtask

  initial begin
    int guard;
    preset = 1'b1; control = '0; pixels_per_row = '0; ram_word = 32'h0A50_0F31;
    prev_rd = 1'b0; n_rd_adj = 0; rgb_clk = '0; addr_lat = '0;
    repeat (3) @(negedge pclk);
    check("rst_oe_n", 32'(hub_oe_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_clk_lat_fd", 32'({hub_clk, hub_lat, frame_done}), 32'd0);
    check("rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
    check("rst_addr", 32'({hub_addr, rd_addr}), 32'd0);
    preset = 1'b0;
    tick();

    // full frame: timing, data and row address per plane
    pixels_per_row = 9'd4; control = 32'd1;
    for (int p = 0; p < 8; p++) begin
      run_plane();
      check("plane_hub_clk_count", 32'(n_clk), 32'd4);
      check("plane_latch_count", 32'(n_lat), 32'd1);
      check("plane_oe_low_cycles", 32'(n_oe), 32'(exp_oe[p % 4]));
      check("plane_rgb", 32'(rgb_clk), 32'(exp_rgb[p % 4]));
      check("plane_hub_addr", 32'(addr_lat), 32'(p / 4));
      check("plane_frame_done", 32'(n_fd), (p == 7) ? 32'd1 : 32'd0);
    end

    // read address sequence and strobe spacing
    check("rd_count", 32'(addr_q.size()), 32'd33);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr_row0", 32'(addr_q[i]), 32'(i));
      check("rd_addr_row1", 32'(addr_q[16 + i]), 32'h200 + 32'(i));
    end
    check("rd_addr_wrap", 32'(addr_q[32]), 32'h000);
    check("rd_gap_c0_c1", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
    check("rd_gap_c2_c3", 32'(rd_cyc[3] - rd_cyc[2]), 32'd2);
    check("rd_adjacent", 32'(n_rd_adj), 32'd0);

    // enable drop mid-DISPLAY on row 1, then restart from row 0
    repeat (5) run_plane();
    guard = 0;
    do begin tick(); guard++; end while (!hub_lat && guard < 3000);
    repeat (3) tick();
    check("oe_on_before_drop", 32'(hub_oe_n), 32'd0);
    control = 32'd0;
    tick();
    check("drop_oe_n", 32'(hub_oe_n), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_rd_en", 32'(rd_en), 32'd0);
    repeat (2) tick();
    control = 32'd1;
    tick();
    check("restart_rd_en", 32'(rd_en), 32'd1);
    check("restart_rd_addr", 32'(rd_addr), 32'h000);

    // ppr=0 holds IDLE; mid-frame ppr change applies at wrap; ppr=0 at wrap returns to IDLE
    control = 32'd0;
    tick();
    pixels_per_row = 9'd0; control = 32'd1;
    n_clk = 0;
    repeat (20) tick();
    check("ppr0_hub_clk", 32'(n_clk), 32'd0);
    check("ppr0_busy", 32'(busy), 32'd0);
    pixels_per_row = 9'd4;
    run_plane();
    check("ppr4_first_plane_clk", 32'(n_clk), 32'd4);
    pixels_per_row = 9'd2;
    for (int p = 1; p < 8; p++) begin
      run_plane();
      check("ppr_change_ignored_clk", 32'(n_clk), 32'd4);
    end
    check("ppr_change_frame_done", 32'(n_fd), 32'd1);
    run_plane();
    check("ppr2_after_wrap_clk", 32'(n_clk), 32'd2);
    pixels_per_row = 9'd0;
    for (int p = 1; p < 8; p++) run_plane();
    check("ppr0_wrap_last_clk", 32'(n_clk), 32'd2);
    check("ppr0_wrap_frame_done", 32'(n_fd), 32'd1);
    check("ppr0_wrap_busy", 32'(busy), 32'd0);
    check("ppr0_wrap_oe_n", 32'(hub_oe_n), 32'd1);

    // brightness field, then asynchronous reset mid-SHIFT
    pixels_per_row = 9'd4; control = 32'h0000_7F01;
    for (int p = 0; p < 4; p++) begin
      run_plane();
      check("bright_oe_low_cycles", 32'(n_oe), 32'(exp_br[p]));
    end
    guard = 0;
    do begin tick(); guard++; end while (!hub_clk && guard < 100);
    check("shift_clk_reached", 32'(hub_clk), 32'd1);
    preset = 1'b1;
    #1;
    check("async_rst_clk", 32'(hub_clk), 32'd0);
    check("async_rst_oe_n", 32'(hub_oe_n), 32'd1);
    check("async_rst_busy_rd", 32'({busy, rd_en}), 32'd0);
    check("async_rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
    check("async_rst_rd_addr", 32'(rd_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
